sysarr_input_fifo_bank: RTL
===========================

// Module: sysarr_input_fifo_bank
// PURPOSE
//  Per-row input staging FIFOs directly upstream of the systolic array.
//  - Accepts one N-element input row from memory per cycle when input_en is high.
//  - Element i of each row is stored in row FIFO i.
//  - Each FIFO presents its head word to array row i and pops it on in_fifo_shift[i] from the array control unit.
//  - The control unit staggers those shifts to apply the diagonal skew.
//  - Exports occupancy flags so the control unit can derive fifo_has_space.
// PARAMETERS
//  N      4   array dimension = number of row FIFOs
//  DW     16  data word width, bits
//  DEPTH  4   entries per row FIFO; power of two, >=2
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  nRST           in   1      asynchronous active-low reset
//  input_en       in   1      row_in holds a valid input row (push request)
//  row_in         in   N*DW   input row; element i = row_in[i*DW +: DW]
//  clear          in   1      synchronous flush of all FIFOs
//  in_fifo_shift  in   N      per-row pop request from control unit
//  row_out        out  N*DW   head word of each FIFO (0 when that FIFO is empty)
//  row_valid      out  N      FIFO i non-empty
//  fifo_full      out  N      FIFO i holds DEPTH entries
//  all_space      out  1      every FIFO has >=1 free entry (push would be accepted)
//  ovf_err        out  1      sticky: push dropped because a FIFO was full
//  udf_err        out  1      sticky: pop requested on an empty FIFO
// BEHAVIOUR
//  - Reset (nRST=0, async): all pointers and counts = 0. Outputs:
//    row_out=0, row_valid=0, fifo_full=0, all_space=1, ovf_err=0, udf_err=0.
//  - Storage: N independent circular buffers.
//    - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//    - count is $clog2(DEPTH+1) bits.
//  - Push: accepted iff input_en && all_space, evaluated on pre-edge state. A pop in the same cycle does NOT free space for the push.
//    - An accepted push writes all N FIFOs in lockstep; every wr_ptr advances.
//    - input_en && !all_space: the row is dropped, no FIFO changes, ovf_err<=1.
//  - Pop: in_fifo_shift[i] && row_valid[i] advances rd_ptr[i] and decrements count[i].
//    - in_fifo_shift[i] && !row_valid[i] is ignored and sets udf_err<=1.
//  - Simultaneous accepted push and pop on FIFO i: count[i] unchanged, both pointers advance.
//  - Latency: a pushed word is visible on row_out one cycle after the push edge if its FIFO was empty (no fall-through).
//  - row_out, row_valid, fifo_full and all_space are decoded from registered state; no combinational path from any input.
//  - clear=1: all pointers and counts -> 0 at the next edge.
//    - clear overrides a push or pop in the same cycle.
//    - A push or pop in that cycle does not set ovf_err or udf_err.
//    - ovf_err/udf_err keep their value; they are cleared only by reset.
//  - Reset mid-operation: all contents are discarded immediately, asynchronously.
// CONFIGURATION
//  SYSARR_IN_FIFO_ZERO_FLAG_EN
//  - Defined: extra output head_zero [N]; head_zero[i] = row_valid[i] && (head word i == 0).
//    - The sparsity logic uses it to skip zero operands. Registered-state decode, reset value 0.
//  - Undefined: port head_zero does not exist; all other behaviour is identical.
// TESTING
//  1. Reset: nRST=0 mid-traffic -> row_valid=0, all_space=1, ovf_err=udf_err=0, row_out=0.
//  2. N=4,DEPTH=4: push rows {1,2,3,4},{5,6,7,8} -> next cycle row_out={1,2,3,4}. Pop row0 only -> row_out[0]=5, rows1-3 still 2,3,4.
//  3. Fill: 4 pushes, no pops -> fifo_full=4'hF, all_space=0. 5th push dropped, ovf_err=1, contents unchanged.
//  4. Full + push + pop on row0 same cycle -> push dropped, ovf_err=1, count[0]=3.
//  5. Wrap: 10 push/pop cycles streaming values 0..9 on all rows -> pops return 0..9 in order, no errors.
//  6. Pop on empty row2 -> udf_err=1, other rows unaffected. clear with push asserted -> all empty, ovf_err unchanged.
//     With ZERO_FLAG_EN, push {0,7,0,9} -> head_zero=4'b0101.

Source files
------------

// File: rtl/sysarr_input_fifo_bank.sv
// Per-row input staging FIFOs feeding the systolic array: one lockstep push of a whole row, independent per-row pops.
// Optional head_zero output (sparsity hint) is enabled by defining SYSARR_IN_FIFO_ZERO_FLAG_EN.
module sysarr_input_fifo_bank #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            input_en,
    input  logic [N*DW-1:0] row_in,
    input  logic            clear,
    input  logic [N-1:0]    in_fifo_shift,
    output logic [N*DW-1:0] row_out,
    output logic [N-1:0]    row_valid,
    output logic [N-1:0]    fifo_full,
    output logic            all_space,
`ifdef SYSARR_IN_FIFO_ZERO_FLAG_EN
    output logic [N-1:0]    head_zero,
`endif
    output logic            ovf_err,
    output logic            udf_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: the producer offers a row with input_en; it is taken on the edge only if all_space
    // was high before that edge. Row i's consumer sees row_valid[i]/row_out[i] and takes the head word
    // by raising in_fifo_shift[i]; a shift without row_valid is an error, not a stall.
    logic         push_ok;
    logic         push_drop;
    logic [N-1:0] pop_ok;
    logic [N-1:0] pop_bad;

    assign push_ok   = input_en && all_space && !clear;
    assign push_drop = input_en && !all_space && !clear;
    assign pop_ok    = in_fifo_shift & row_valid & {N{!clear}};
    assign pop_bad   = in_fifo_shift & ~row_valid & {N{!clear}};
    assign all_space = ~|fifo_full;

    for (genvar g = 0; g < N; g++) begin : g_row
        logic [DW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] count;

        assign row_valid[g] = (count != '0);
        assign fifo_full[g] = (count == CW'(DEPTH));
        assign row_out[g*DW +: DW] = row_valid[g] ? mem[rd_ptr] : '0;
`ifdef SYSARR_IN_FIFO_ZERO_FLAG_EN
        assign head_zero[g] = row_valid[g] && (mem[rd_ptr] == '0);
`endif

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok)   wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok[g]) rd_ptr <= rd_ptr + PW'(1);
                case ({push_ok, pop_ok[g]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage is not reset: row_out is masked by row_valid, so stale words never escape.
        always_ff @(posedge CLK) begin
            if (push_ok) mem[wr_ptr] <= row_in[g*DW +: DW];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (push_drop)  ovf_err <= 1'b1;
            if (|pop_bad)   udf_err <= 1'b1;
        end
    end

endmodule
